// File: rtl/seq_mult_shift_add_if.sv
// Handshake/operand bundle for seq_mult_shift_add.
// master: drives START/A/B(/TC); slave: returns P/READY/BUSY/DONE.
interface seq_mult_shift_add_if #(
  parameter int WIDTH = 4
);
  logic               START;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
`ifdef SEQ_MULT_SIGNED_EN
  logic               TC;
`endif
  logic [2*WIDTH-1:0] P;
  logic               READY;
  logic               BUSY;
  logic               DONE;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (
    output START, A, B, TC,
    input  P, READY, BUSY, DONE
  );
  modport slave (
    input  START, A, B, TC,
    output P, READY, BUSY, DONE
  );
`else
  modport master (
    output START, A, B,
    input  P, READY, BUSY, DONE
  );
  modport slave (
    input  START, A, B,
    output P, READY, BUSY, DONE
  );
`endif
endinterface

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one step/cycle.
// Ports: CK, RST (sync, active-high), bus (slave: START,A,B,[TC] -> P,READY,BUSY,DONE).
// Macro SEQ_MULT_SIGNED_EN adds TC (two's-complement mode) on the bus.
module seq_mult_shift_add #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic CK,
  input  logic RST,
  seq_mult_shift_add_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

`ifdef SEQ_MULT_SIGNED_EN
  logic tc_q, tc_d;
`else
  logic tc_q;
  assign tc_q = 1'b0;
`endif

  logic [WIDTH-1:0]   hi;
  logic [WIDTH:0]     ext_hi;
  logic [WIDTH:0]     ext_m;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;
  logic               last;

  // One step: add (or, on the signed sign-bit step, subtract) the
  // multiplicand into the upper half at WIDTH+1 bits, then shift right
  // with the extra bit becoming the new MSB.
  always_comb begin
    hi     = acc_q[2*WIDTH-1:WIDTH];
    ext_hi = {tc_q & hi[WIDTH-1], hi};
    ext_m  = {tc_q & mcand_q[WIDTH-1], mcand_q};
    last   = (cnt_q == CW'(WIDTH - 1));
    if (!acc_q[0])
      sum = ext_hi;
    else if (tc_q && last)
      sum = ext_hi - ext_m;
    else
      sum = ext_hi + ext_m;
    step = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef SEQ_MULT_SIGNED_EN
    tc_d    = tc_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          mcand_d = bus.A;
          acc_d   = {{WIDTH{1'b0}}, bus.B};
          cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
          tc_d    = bus.TC;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          p_d     = step;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      tc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      tc_q    <= tc_d;
`endif
    end
  end

  assign bus.P     = p_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Randomized + directed bench for seq_mult_shift_add.
// Reference product from plain integer arithmetic.
module tb_seq_mult_shift_add;

  localparam int W = 4;

  logic CK;
  logic RST;
  int   checks;
  int   errors;
  logic [2*W-1:0] last_p;

  seq_mult_shift_add_if #(.WIDTH(W)) bus ();

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic tc);
    longint sa, sb, pr;
    sa = longint'(a);
    sb = longint'(b);
    if (tc && a[W-1]) sa = sa - (longint'(1) << W);
    if (tc && b[W-1]) sb = sb - (longint'(1) << W);
    pr = sa * sb;
    return pr[2*W-1:0];
  endfunction

  task automatic set_tc(input logic tc);
`ifdef SEQ_MULT_SIGNED_EN
    bus.TC = tc;
`else
    if (tc) $display("note: tc ignored in unsigned build");
`endif
  endtask

  // Called in an IDLE or DONE cycle (#1 after an edge). Ends in the
  // DONE cycle with START left at 'hold'.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic tc,
                        input bit hold,
                        input bit scr);
    logic [2*W-1:0] exp;
    exp = model(a, b, tc);
    chk("ready_pre", bus.READY, 1);
    bus.A     = a;
    bus.B     = b;
    set_tc(tc);
    bus.START = 1'b1;
    @(posedge CK); #1;
    for (int i = 0; i < W; i++) begin
      chk("busy", bus.BUSY, 1);
      chk("ready_run", bus.READY, 0);
      chk("done_early", bus.DONE, 0);
      chk("p_hold", bus.P, last_p);
      if (scr) begin
        bus.START = 1'($urandom);
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        set_tc(1'($urandom));
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CK); #1;
    end
    chk("done", bus.DONE, 1);
    chk("ready_done", bus.READY, 1);
    chk("busy_done", bus.BUSY, 0);
    chk("p", bus.P, exp);
    last_p    = exp;
    bus.START = hold;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rt;
    checks    = 0;
    errors    = 0;
    last_p    = '0;
    RST       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    set_tc(1'b0);
    repeat (2) @(posedge CK);
    #1;
    chk("rst_ready", bus.READY, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_p", bus.P, 0);
    RST = 1'b0;
    @(posedge CK); #1;

    run_op(15, 15, 0, 0, 0);
    chk("p_e1", bus.P, 8'hE1);
    @(posedge CK); #1;
    run_op(0, 9, 0, 0, 0);
    @(posedge CK); #1;
    run_op(9, 0, 0, 0, 0);
    @(posedge CK); #1;
    run_op(10, 13, 0, 0, 1);
    repeat (3) @(posedge CK);
    #1;
    chk("idle_ready", bus.READY, 1);
    chk("idle_done", bus.DONE, 0);
    chk("p_retain", bus.P, 8'h82);

    run_op(3, 5, 0, 1, 0);
    run_op(7, 6, 0, 1, 0);
    run_op(12, 11, 0, 0, 0);
    chk("p_84", bus.P, 8'h84);
    @(posedge CK); #1;
    chk("idle_after_hold", bus.READY, 1);
    chk("busy_after_hold", bus.BUSY, 0);

    bus.A     = 15;
    bus.B     = 15;
    bus.START = 1'b1;
    @(posedge CK); #1;
    bus.START = 1'b0;
    @(posedge CK); #1;
    chk("busy_pre_rst", bus.BUSY, 1);
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
    chk("mid_rst_ready", bus.READY, 1);
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_p", bus.P, 0);
    last_p = '0;
    for (int i = 0; i < W + 2; i++) begin
      chk("mid_rst_done", bus.DONE, 0);
      @(posedge CK); #1;
    end
    run_op(2, 3, 0, 0, 0);
    @(posedge CK); #1;

`ifdef SEQ_MULT_SIGNED_EN
    run_op(4'h8, 4'h7, 1, 0, 0);
    chk("p_c8", bus.P, 8'hC8);
    run_op(4'hF, 4'hF, 1, 0, 0);
    chk("p_01", bus.P, 8'h01);
    run_op(4'h8, 4'h7, 0, 0, 0);
    chk("p_38", bus.P, 8'h38);
    @(posedge CK); #1;
`endif

    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rt = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      rt = 1'($urandom);
`endif
      if (n % 10 == 0) begin
        ra = '1;
        rb = '1;
      end
      run_op(ra, rb, rt, 1'($urandom), 1);
    end

    bus.START = 1'b0;
    @(posedge CK); #1;
    chk("end_ready", bus.READY, 1);
    chk("end_p", bus.P, last_p);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Successor to the fixed 4x4 START/READY shift-add multiplier in the ISCAS-style benchmark set.
- Adds:
  - generic width
  - explicit handshake: READY, BUSY, DONE pulse
  - back-to-back operation
  - synchronous reset
  - optional two's-complement mode
- Used as a sequential fault-sim/ATPG benchmark and as a reusable datapath block.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), step-counter width; derived, not to be overridden.

Ports:
- CK     input   1          rising-edge clock
- RST    input   1          synchronous reset, active-high
- START  input   1          begin multiply; sampled only when READY=1
- A      input   WIDTH      multiplicand; captured on accepted START
- B      input   WIDTH      multiplier; captured on accepted START
- P      output  2*WIDTH    product register; holds last result until the next accepted START
- READY  output  1          block can accept START (state IDLE or DONE)
- BUSY   output  1          multiply in progress (state RUN)
- DONE   output  1          one-cycle pulse; P is valid in the same cycle

Behaviour:
- Single clock CK. Reset is synchronous, active-high, on RST. All flops update on CK rising edge only.
- Reset values:
  - state=IDLE, P=0, READY=1, BUSY=0, DONE=0
  - internal registers (multiplicand reg, step counter, accumulator/shift reg) = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - READY=1.
  - START=1 -> capture A into the multiplicand register; load the accumulator with {WIDTH'b0, B}; counter=0; go to RUN.
  - P is unchanged on entry to RUN.
- RUN, one step per cycle:
  - If acc[0]=1: upper half = upper half + multiplicand, computed at WIDTH+1 bits to keep the carry.
  - Then shift {carry, acc} right by 1. Counter increments.
  - After exactly WIDTH steps (counter==WIDTH-1 on the final step): write the final accumulator to P, go to DONE.
  - READY=0, BUSY=1.
  - START is ignored; A and B changes are ignored.
- DONE:
  - Lasts one cycle. DONE=1, READY=1, BUSY=0.
  - START=1 -> new capture, go to RUN (back-to-back; no idle bubble needed).
  - START=0 -> go to IDLE.
- Latency: START accepted at edge k -> P updated and DONE=1 after edge k+WIDTH. Throughput: one result per WIDTH+1 cycles.
- Arithmetic:
  - Unsigned: P = A*B exactly, no truncation.
  - Max-value case (all ones) must not overflow: the 2*WIDTH product fits.
- RST=1 in any state (including mid-RUN) has priority over START:
  - Next cycle is IDLE with P=0. The partial result is discarded and DONE is not asserted.
- START held high continuously: a new operation starts every WIDTH+1 cycles, accepted in each DONE cycle.
- Outputs READY, BUSY, DONE are decoded from registered state only (no combinational path from START).

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Extra input port TC (1 bit), captured with A and B on an accepted START.
  - TC=1: A and B are two's complement. Partial-product adds sign-extend the multiplicand; the final step (B sign bit) subtracts instead of adds. P is the signed 2*WIDTH product.
  - TC=0: identical to unsigned behaviour.
  - Latency is unchanged.
- Undefined: TC port is absent; unsigned only. Logic is equivalent to the TC=0 case.

Test Plan:
- WIDTH=4, reset then A=15, B=15, 1-cycle START -> BUSY for 4 cycles; DONE pulse on 5th edge after START; P=0x00E1; READY=1 in the DONE cycle.
- A=0, B=9 then A=9, B=0 -> P=0x0000 both times, same latency; P retains value after returning to IDLE.
- START held high; operand pairs (3,5), (7,6), (12,11) presented at each READY -> P=0x000F, 0x002A, 0x0084 at 5-cycle spacing; no lost or duplicated DONE.
- A=10, B=13 START; toggle START and change A/B during RUN -> ignored; P=0x0082.
- RST asserted on the 2nd RUN cycle of A=15, B=15 -> next cycle IDLE, P=0, DONE never pulses. A following START A=2, B=3 -> P=0x0006.
- SEQ_MULT_SIGNED_EN defined, TC=1:
  - A=-8 (0x8), B=7 -> P=0xC8 (-56).
  - A=-1, B=-1 -> P=0x01.
  - TC=0, A=0x8, B=7 -> P=0x38.
